seq_multiplier: RTL
===================

# seq_multiplier

Iterative unsigned shift-and-add multiplier built next to the 32-bit full-adder stage of the ALU. It consumes the adder's sum and carry once per cycle to accumulate partial products. It accepts two WIDTH-bit operands on a start pulse and produces a registered 2*WIDTH-bit product after WIDTH iteration cycles. It gives the ALU a multiply operation without a combinational array multiplier.

## Interface
- WIDTH, 32, operand width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- A  input  WIDTH  multiplicand; captured on the accepted start edge.
- B  input  WIDTH  multiplier; captured on the accepted start edge.
- busy  output  1  high while iterating (state RUN).
- done  output  1  one-cycle pulse; product just updated.
- product  output  2*WIDTH  last completed result; held until the next completion.

## Operation
- Internal registers:
  - mcand (WIDTH): captured A.
  - hi (WIDTH+1): accumulator upper half plus carry.
  - lo (WIDTH): holds the multiplier bits, then the low product bits.
  - cnt (clog2(WIDTH)+1 bits).
  - state: IDLE, RUN, DONE.
- Reset (asynchronous, any state):
  - state=IDLE.
  - busy=0, done=0, product=0.
  - mcand, hi, lo and cnt all cleared.
  - An in-flight operation is abandoned; no done pulse follows.
- IDLE:
  - start=1 at an edge loads mcand=A, lo=B, hi=0, cnt=0, and moves to RUN.
  - start=0 stays in IDLE.
- RUN, at each edge:
  - sum = lo[0] ? ({1'b0,hi[WIDTH-1:0]} + {1'b0,mcand}) : {1'b0,hi[WIDTH-1:0]}. This is a (WIDTH+1)-bit unsigned add, and the carry out is kept.
  - {hi,lo} <= {1'b0, sum, lo} >> 1, so the shifted value is sum concatenated with lo[WIDTH-1:1].
  - cnt <= cnt+1.
  - When cnt==WIDTH-1 at the edge:
    - product <= {sum, lo[WIDTH-1:1]} truncated to 2*WIDTH, which equals the final {hi[WIDTH-1:0], lo}.
    - state moves to DONE.
  - start is ignored in RUN; A and B may change freely without effect.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - start=1 behaves exactly as in IDLE (load and go to RUN), which allows back-to-back operations.
  - Otherwise the next state is IDLE.
- Arithmetic:
  - Unsigned only.
  - Overflow is impossible: the product always fits in 2*WIDTH bits.
  - Zero operands take the full WIDTH cycles; there is no early termination.

## Timing
- busy and done are decoded from registered state; they are glitch-free with no combinational path from inputs.
- Start accepted at edge k:
  - busy=1 from after edge k until after edge k+WIDTH.
  - product updates at edge k+WIDTH.
  - done=1 for the cycle between edges k+WIDTH and k+WIDTH+1.
- Latency: WIDTH clock cycles from the accepting edge to product valid.
- Throughput: one result per WIDTH+1 cycles when start is held high continuously.
- product changes only at a completing edge or at reset. It is stable throughout RUN of a subsequent operation.
- Reset asserted mid-RUN: outputs clear immediately (asynchronously). The first legal start is at the first edge after reset deasserts.

## Test plan
- Basic: reset, then start with A=3, B=5 at edge k (WIDTH=32).
  - busy high for 32 cycles.
  - done pulses once after edge k+32.
  - product=15.
- Max operands: A=B=0xFFFFFFFF.
  - product=0xFFFFFFFE00000001.
  - Carry into the hi register is exercised every cycle.
- Zero and mid-run changes: A=0, B=0x12345678, with A and B toggled randomly during RUN.
  - product=0 after 32 cycles.
  - A second start pulse sent mid-RUN is ignored: exactly one done pulse.
- Back-to-back: start held high continuously with A=7, B=9, then A=0x10000, B=0x10000 applied in the DONE cycle.
  - First done gives product=63.
  - Second done arrives 33 cycles later with product=0x100000000.
  - Between the two dones, product holds 63.
- Reset mid-op: start with A=B=0xFFFF, then assert reset at cycle 10.
  - busy, done and product read 0 immediately.
  - No done pulse follows.
  - A fresh start with A=2, B=4 yields product=8 after 32 cycles.
- Parameter check: WIDTH=4 with A=0xF, B=0xF.
  - product=0xE1 after 4 cycles.
  - done width is 1 cycle.

Source files
------------

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//
// Iterative unsigned shift-and-add multiplier. One partial product is folded
// into the accumulator per clock, so a WIDTH x WIDTH multiply completes
// WIDTH cycles after the start edge that loads the operands.
//
// Handshake: a start request is accepted on a rising edge only while the
// block is IDLE or DONE; in RUN start is ignored. done is a one-cycle pulse
// marking the cycle in which product has just been updated. product holds
// the last completed result until the next completion (or reset).
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      request; sampled only in IDLE or DONE
//   A          multiplicand, captured on the accepted start edge
//   B          multiplier, captured on the accepted start edge
//   busy       high while iterating (state RUN)
//   done       one-cycle pulse after the completing edge
//   product    last completed 2*WIDTH-bit result
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
// -----------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH:0]       r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH:0]       w_addend;
  logic [WIDTH:0]       w_sum;

  // The top bit of r_hi is always zero after a shift, so adding the full
  // (WIDTH+1)-bit register is the same as adding {1'b0, hi[WIDTH-1:0]}.
  // The sum cannot exceed WIDTH+1 bits, so the carry out is kept in w_sum[WIDTH].
  assign w_addend = r_lo[0] ? {1'b0, r_mcand} : '0;
  assign w_sum    = r_hi + w_addend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        // DONE behaves like IDLE for a new request, which gives back-to-back
        // operation with one result every WIDTH+1 cycles.
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mcand <= A;
            r_lo    <= B;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_RUN: begin
          // Shift {sum, lo} right by one: the sum's low bit becomes the next
          // product bit entering lo from the top, the consumed multiplier bit
          // falls out of lo[0].
          r_hi  <= {1'b0, w_sum[WIDTH:1]};
          r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) begin
            // Same value the shifted {hi[WIDTH-1:0], lo} will hold after this edge.
            r_product <= {w_sum, r_lo[WIDTH-1:1]};
            r_state   <= S_DONE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pure decodes of registered state: no path from any input.
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign product   = r_product;
  assign dbg_state = r_state;

endmodule
